// File: rtl/in_decimal_entry_if.sv
// Request/valid handshake between the core and the decimal entry block.
interface in_decimal_entry_if;
  logic       request;
  logic [8:0] dataIn;
  logic       valid;

  modport master (output request, input dataIn, input valid);
  modport slave  (input request, output dataIn, output valid);
endinterface

// File: rtl/in_decimal_entry.sv
// Operator decimal entry: three BCD digits plus sign, keyed in on push-buttons,
// range-checked and handed to the core as a 9-bit two's-complement word.
module in_decimal_entry (
  input  logic              clock,
  input  logic              reset,
  in_decimal_entry_if.slave bus,
  input  logic [3:0]        digit,
  input  logic              key_digit,
  input  logic              key_sign,
  input  logic              key_enter,
  input  logic              key_clear,
  output logic              waiting,
  output logic              error,
  output logic [3:0]        bcd1,
  output logic [3:0]        bcd2,
  output logic [3:0]        bcd3,
  output logic              negative
);

  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, DONE} state_e;

  localparam int K_DIGIT = 0;
  localparam int K_SIGN  = 1;
  localparam int K_ENTER = 2;
  localparam int K_CLEAR = 3;

  state_e     state, state_nxt;
  logic [3:0] key_r, key_q, digit_r;
  logic [3:0] key_edge;
  logic [3:0] bcd1_nxt, bcd2_nxt, bcd3_nxt;
  logic [1:0] count, count_nxt;
  logic       negative_nxt, error_nxt;
  logic [8:0] data, data_nxt;
  logic [9:0] mag, mag_neg;
  logic       legal;

  // Keys pass through one register stage before edge detection, so a press
  // first sampled at one edge acts at the following edge.
  assign key_edge = key_r & ~key_q;

  assign mag     = 10'(bcd3) * 10'd100 + 10'(bcd2) * 10'd10 + 10'(bcd1);
  assign mag_neg = ~mag + 10'd1;
  assign legal   = negative ? (mag <= 10'd256) : (mag <= 10'd255);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      key_r    <= '0;
      key_q    <= '0;
      digit_r  <= '0;
      bcd1     <= '0;
      bcd2     <= '0;
      bcd3     <= '0;
      count    <= '0;
      negative <= 1'b0;
      error    <= 1'b0;
      data     <= '0;
    end else begin
      state    <= state_nxt;
      key_r    <= {key_clear, key_enter, key_sign, key_digit};
      key_q    <= key_r;
      digit_r  <= digit;
      bcd1     <= bcd1_nxt;
      bcd2     <= bcd2_nxt;
      bcd3     <= bcd3_nxt;
      count    <= count_nxt;
      negative <= negative_nxt;
      error    <= error_nxt;
      data     <= data_nxt;
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt    = state;
    bcd1_nxt     = bcd1;
    bcd2_nxt     = bcd2;
    bcd3_nxt     = bcd3;
    count_nxt    = count;
    negative_nxt = negative;
    error_nxt    = error;
    data_nxt     = data;

    unique case (state)
      IDLE: begin
        if (bus.request) begin
          state_nxt    = ENTRY;
          bcd1_nxt     = '0;
          bcd2_nxt     = '0;
          bcd3_nxt     = '0;
          count_nxt    = '0;
          negative_nxt = 1'b0;
          error_nxt    = 1'b0;
        end
      end

      ENTRY: begin
        // A withdrawn request wins over any key event in the same cycle.
        if (!bus.request) begin
          state_nxt = IDLE;
        end else if (key_edge[K_CLEAR]) begin
          bcd1_nxt     = '0;
          bcd2_nxt     = '0;
          bcd3_nxt     = '0;
          count_nxt    = '0;
          negative_nxt = 1'b0;
          error_nxt    = 1'b0;
        end else if (key_edge[K_ENTER]) begin
          state_nxt = CHECK;
        end else if (key_edge[K_SIGN]) begin
          negative_nxt = ~negative;
          error_nxt    = 1'b0;
        end else if (key_edge[K_DIGIT] && digit_r <= 4'd9 && count != 2'd3) begin
          bcd3_nxt  = bcd2;
          bcd2_nxt  = bcd1;
          bcd1_nxt  = digit_r;
          count_nxt = count + 2'd1;
          error_nxt = 1'b0;
        end
      end

      CHECK: begin
        if (legal) begin
          data_nxt  = negative ? mag_neg[8:0] : mag[8:0];
          error_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          error_nxt = 1'b1;
          state_nxt = ENTRY;
        end
      end

      DONE: begin
        if (!bus.request) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.valid  = (state == DONE);
  assign bus.dataIn = data;
  assign waiting    = (state == ENTRY);

endmodule

// File: tb/tb_in_decimal_entry.sv
// Self-checking bench for in_decimal_entry: directed vector table, random key
// sequences against a digit-queue reference model, and multi-cycle corner cases.
module tb_in_decimal_entry;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] digit;
  logic       key_digit, key_sign, key_enter, key_clear;
  logic       waiting, error, negative;
  logic [3:0] bcd1, bcd2, bcd3;

  in_decimal_entry_if bus ();

  in_decimal_entry dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .digit    (digit),
    .key_digit(key_digit),
    .key_sign (key_sign),
    .key_enter(key_enter),
    .key_clear(key_clear),
    .waiting  (waiting),
    .error    (error),
    .bcd1     (bcd1),
    .bcd2     (bcd2),
    .bcd3     (bcd3),
    .negative (negative)
  );

  always #5 clock = ~clock;

  typedef enum int {A_DIG, A_SIGN, A_ENTER, A_CLEAR, A_REL} act_e;

  typedef struct {
    act_e       act;
    logic [3:0] val;
    logic [11:0] echo;   // {bcd3, bcd2, bcd1}
    logic       neg;
    logic       vld;
    logic       err;
    logic [8:0] data;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  // Reference model: the entry as a queue of decimal digits.
  int   q[$];
  bit   mneg, merr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic press(input act_e a, input logic [3:0] d);
    digit = d;
    case (a)
      A_DIG:   key_digit = 1'b1;
      A_SIGN:  key_sign  = 1'b1;
      A_ENTER: key_enter = 1'b1;
      default: key_clear = 1'b1;
    endcase
    tick();
    key_digit = 1'b0;
    key_sign  = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    tick();
  endtask

  task automatic do_action(input act_e a, input logic [3:0] d);
    if (a == A_REL) begin
      bus.request = 1'b0;
      tick();
      check("release_valid", 32'(bus.valid), 32'd0);
      check("release_waiting", 32'(waiting), 32'd0);
      bus.request = 1'b1;
      tick();
    end else begin
      press(a, d);
      if (a == A_ENTER) begin
        check("enter_latency", 32'(bus.valid), 32'd0);
        tick();
      end
    end
  endtask

  task automatic compare(input string tag, input logic [11:0] echo, input logic neg,
                         input logic vld, input logic err, input logic [8:0] data);
    check({tag, "_echo"}, 32'({bcd3, bcd2, bcd1}), 32'(echo));
    check({tag, "_flags"}, 32'({negative, bus.valid, error, waiting}),
          32'({neg, vld, err, ~vld}));
    if (vld) check({tag, "_data"}, 32'(bus.dataIn), 32'(data));
  endtask

  function automatic vec_t mk(act_e a, int val, logic [11:0] echo, logic neg,
                              logic vld, logic err, logic [8:0] data);
    vec_t v;
    v.act  = a;
    v.val  = 4'(val);
    v.echo = echo;
    v.neg  = neg;
    v.vld  = vld;
    v.err  = err;
    v.data = data;
    return v;
  endfunction

  function automatic logic [11:0] model_echo();
    logic [3:0] b1, b2, b3;
    int n = q.size();
    b1 = (n >= 1) ? 4'(q[n-1]) : 4'd0;
    b2 = (n >= 2) ? 4'(q[n-2]) : 4'd0;
    b3 = (n >= 3) ? 4'(q[n-3]) : 4'd0;
    return {b3, b2, b1};
  endfunction

  initial begin
    reset       = 1'b1;
    bus.request = 1'b0;
    digit       = '0;
    key_digit   = 1'b0;
    key_sign    = 1'b0;
    key_enter   = 1'b0;
    key_clear   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_echo", 32'({bcd3, bcd2, bcd1}), 32'd0);
    check("reset_flags", 32'({negative, bus.valid, error, waiting}), 32'd0);
    check("reset_data", 32'(bus.dataIn), 32'd0);

    bus.request = 1'b1;
    tick();
    check("request_to_waiting", 32'(waiting), 32'd1);

    // Directed vectors: action, value, expected echo/neg/valid/error/data.
    vecs.push_back(mk(A_DIG,   1,  12'h001, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   2,  12'h012, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   3,  12'h123, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h123, 0, 1, 0, 9'h07B));
    vecs.push_back(mk(A_REL,   0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   2,  12'h002, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   5,  12'h025, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   6,  12'h256, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_SIGN,  0,  12'h256, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h256, 1, 1, 0, 9'h100));
    vecs.push_back(mk(A_REL,   0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   2,  12'h002, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   5,  12'h025, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   6,  12'h256, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h256, 0, 0, 1, 9'h000));
    vecs.push_back(mk(A_CLEAR, 0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   9,  12'h009, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   9,  12'h099, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   9,  12'h999, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   7,  12'h999, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   12, 12'h999, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_CLEAR, 0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h000, 0, 1, 0, 9'h000));
    vecs.push_back(mk(A_REL,   0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_SIGN,  0,  12'h000, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   5,  12'h005, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h005, 1, 1, 0, 9'h1FB));
    vecs.push_back(mk(A_REL,   0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_SIGN,  0,  12'h000, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_SIGN,  0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   5,  12'h005, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h005, 0, 1, 0, 9'h005));
    vecs.push_back(mk(A_REL,   0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_SIGN,  0,  12'h000, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h000, 1, 1, 0, 9'h000));
    vecs.push_back(mk(A_REL,   0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   2,  12'h002, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   5,  12'h025, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   5,  12'h255, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h255, 0, 1, 0, 9'h0FF));
    vecs.push_back(mk(A_REL,   0,  12'h000, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_SIGN,  0,  12'h000, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   2,  12'h002, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   5,  12'h025, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_DIG,   7,  12'h257, 1, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h257, 1, 0, 1, 9'h000));
    vecs.push_back(mk(A_SIGN,  0,  12'h257, 0, 0, 0, 9'h000));
    vecs.push_back(mk(A_ENTER, 0,  12'h257, 0, 0, 1, 9'h000));
    vecs.push_back(mk(A_CLEAR, 0,  12'h000, 0, 0, 0, 9'h000));

    for (int i = 0; i < vecs.size(); i++) begin
      do_action(vecs[i].act, vecs[i].val);
      compare($sformatf("vec%0d", i), vecs[i].echo, vecs[i].neg, vecs[i].vld,
              vecs[i].err, vecs[i].data);
    end

    // Random key sequences against the digit-queue model; entry starts empty.
    q.delete();
    mneg = 1'b0;
    merr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      int d = $urandom_range(0, 15);
      act_e a;
      if (r <= 5)      a = A_DIG;
      else if (r == 6) a = A_SIGN;
      else if (r == 7) a = A_CLEAR;
      else             a = A_ENTER;
      if (a == A_DIG && merr && (d > 9 || q.size() == 3)) a = A_SIGN;
      do_action(a, 4'(d));
      case (a)
        A_DIG: begin
          if (d <= 9 && q.size() < 3) begin
            q.push_back(d);
            merr = 1'b0;
          end
        end
        A_SIGN: begin
          mneg = ~mneg;
          merr = 1'b0;
        end
        A_CLEAR: begin
          q.delete();
          mneg = 1'b0;
          merr = 1'b0;
        end
        default: ;
      endcase
      if (a == A_ENTER) begin
        int mag = 0;
        foreach (q[j]) mag = mag * 10 + q[j];
        if (mag <= (mneg ? 256 : 255)) begin
          logic [8:0] expd = mneg ? 9'((512 - mag) % 512) : 9'(mag);
          compare($sformatf("rnd%0d_commit", i), model_echo(), mneg, 1'b1, 1'b0, expd);
          do_action(A_REL, 4'd0);
          q.delete();
          mneg = 1'b0;
          merr = 1'b0;
          compare($sformatf("rnd%0d_rearm", i), 12'h000, 1'b0, 1'b0, 1'b0, 9'h000);
        end else begin
          merr = 1'b1;
          compare($sformatf("rnd%0d_range", i), model_echo(), mneg, 1'b0, 1'b1, 9'h000);
        end
      end else begin
        compare($sformatf("rnd%0d", i), model_echo(), mneg, 1'b0, merr, 9'h000);
      end
    end

    // Enter and digit rising together: only the enter acts.
    do_action(A_CLEAR, 4'd0);
    do_action(A_DIG, 4'd1);
    digit     = 4'd7;
    key_digit = 1'b1;
    key_enter = 1'b1;
    tick();
    key_digit = 1'b0;
    key_enter = 1'b0;
    tick();
    tick();
    compare("enter_beats_digit", 12'h001, 1'b0, 1'b1, 1'b0, 9'h001);
    do_action(A_REL, 4'd0);

    // Keys held for ten cycles produce one event each.
    digit     = 4'd4;
    key_digit = 1'b1;
    repeat (10) tick();
    key_digit = 1'b0;
    tick();
    check("held_digit_once", 32'({bcd3, bcd2, bcd1}), 32'h004);
    key_sign = 1'b1;
    repeat (10) tick();
    key_sign = 1'b0;
    tick();
    check("held_sign_once", 32'(negative), 32'd1);

    // Request withdrawn mid-entry; echo cleared on the next request.
    bus.request = 1'b0;
    tick();
    check("midentry_drop_waiting", 32'(waiting), 32'd0);
    tick();
    bus.request = 1'b1;
    tick();
    compare("midentry_rearm", 12'h000, 1'b0, 1'b0, 1'b0, 9'h000);

    // Reset while DONE.
    do_action(A_DIG, 4'd4);
    do_action(A_DIG, 4'd2);
    do_action(A_ENTER, 4'd0);
    compare("pre_reset_done", 12'h042, 1'b0, 1'b1, 1'b0, 9'h02A);
    reset = 1'b1;
    tick();
    check("reset_in_done_valid", 32'(bus.valid), 32'd0);
    check("reset_in_done_data", 32'(bus.dataIn), 32'd0);
    check("reset_in_done_echo", 32'({bcd3, bcd2, bcd1}), 32'd0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
